// File: rtl/plic_target_ctrl.sv
// plic_target_ctrl: per-target claim/complete controller of the PLIC.
// Picks the highest-priority enabled pending source above the threshold,
// raises irq_o, and runs the claim/complete handshake towards the gateways.
module plic_target_ctrl #(
    parameter int unsigned SRC_NUM    = 8,
    parameter int unsigned PRIO_WIDTH = 3,
    parameter int unsigned ID_WIDTH   = $clog2(SRC_NUM + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [SRC_NUM-1:0]            ip_i,
    input  logic [SRC_NUM-1:0]            ie_i,
    input  logic [SRC_NUM*PRIO_WIDTH-1:0] prio_i,
    input  logic [PRIO_WIDTH-1:0]         thold_i,
    input  logic                          claim_req_i,
    output logic                          claim_vld_o,
    output logic [ID_WIDTH-1:0]           claim_id_o,
    input  logic                          comp_req_i,
    input  logic [ID_WIDTH-1:0]           comp_id_i,
    output logic [SRC_NUM-1:0]            clam_o,
    output logic [SRC_NUM-1:0]            comp_o,
    output logic                          irq_o,
    output logic [SRC_NUM-1:0]            claimed_o
);

    logic [SRC_NUM-1:0]    claimed_q, claimed_d;
    logic [ID_WIDTH-1:0]   best_id_q, best_id_d;
    logic [PRIO_WIDTH-1:0] best_prio_q, best_prio_d;
    logic                  claim_vld_q, claim_vld_d;
    logic [ID_WIDTH-1:0]   claim_id_q, claim_id_d;
    logic [SRC_NUM-1:0]    clam_q, clam_d;
    logic [SRC_NUM-1:0]    comp_q, comp_d;

    logic [SRC_NUM-1:0]    claim_hit;
    logic [SRC_NUM-1:0]    comp_hit;
    logic [SRC_NUM-1:0]    eligible;

    // Decode the claim/complete strobes into per-source hits and eligibility.
    // IDs 0 and above SRC_NUM never match a source, so they drop out naturally.
    always_comb begin
        claim_hit = '0;
        comp_hit  = '0;
        eligible  = '0;
        for (int unsigned k = 0; k < SRC_NUM; k++) begin
            claim_hit[k] = claim_req_i && (best_id_q == ID_WIDTH'(k + 1));
            comp_hit[k]  = comp_req_i && (comp_id_i == ID_WIDTH'(k + 1)) && claimed_q[k];
            eligible[k]  = ip_i[k] && ie_i[k] && !claimed_q[k]
                         && (prio_i[k*PRIO_WIDTH +: PRIO_WIDTH] > thold_i)
                         && !claim_hit[k];
        end
    end

    // Arbitration: strictly-greater update while scanning upwards keeps the
    // lowest ID on priority ties; eligible sources always have prio >= 1.
    always_comb begin
        best_id_d   = '0;
        best_prio_d = '0;
        for (int unsigned k = 0; k < SRC_NUM; k++) begin
            if (eligible[k] && (prio_i[k*PRIO_WIDTH +: PRIO_WIDTH] > best_prio_d)) begin
                best_id_d   = ID_WIDTH'(k + 1);
                best_prio_d = prio_i[k*PRIO_WIDTH +: PRIO_WIDTH];
            end
        end
    end

    // Next-state for the handshake: claim sets, complete clears, independently.
    always_comb begin
        claim_vld_d = claim_req_i;
        claim_id_d  = claim_req_i ? best_id_q : '0;
        clam_d      = claim_hit;
        comp_d      = comp_hit;
        claimed_d   = (claimed_q | claim_hit) & ~comp_hit;
    end

    // State and registered outputs; reset wins over any strobe at the same edge.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            claimed_q   <= '0;
            best_id_q   <= '0;
            best_prio_q <= '0;
            claim_vld_q <= 1'b0;
            claim_id_q  <= '0;
            clam_q      <= '0;
            comp_q      <= '0;
        end else begin
            claimed_q   <= claimed_d;
            best_id_q   <= best_id_d;
            best_prio_q <= best_prio_d;
            claim_vld_q <= claim_vld_d;
            claim_id_q  <= claim_id_d;
            clam_q      <= clam_d;
            comp_q      <= comp_d;
        end
    end

    // A non-zero best ID always carries a non-zero priority, so both terms agree.
    assign irq_o       = (best_id_q != '0) && (best_prio_q != '0);
    assign claim_vld_o = claim_vld_q;
    assign claim_id_o  = claim_id_q;
    assign clam_o      = clam_q;
    assign comp_o      = comp_q;
    assign claimed_o   = claimed_q;

endmodule

// File: tb/tb_plic_target_ctrl.sv
// Self-checking bench for plic_target_ctrl: directed scenarios plus a
// randomized run against a priority-scan reference model.
module tb_plic_target_ctrl;

    localparam int N  = 8;
    localparam int PW = 3;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  ip, ie;
    logic [N*PW-1:0] prio;
    logic [PW-1:0] thold;
    logic          claim_req, comp_req;
    logic [IW-1:0] comp_id;
    logic          claim_vld, irq;
    logic [IW-1:0] claim_id;
    logic [N-1:0]  clam, comp, claimed;

    int n_cmp  = 0;
    int n_fail = 0;

    plic_target_ctrl #(.SRC_NUM(N), .PRIO_WIDTH(PW)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .ip_i(ip), .ie_i(ie), .prio_i(prio),
        .thold_i(thold), .claim_req_i(claim_req), .claim_vld_o(claim_vld),
        .claim_id_o(claim_id), .comp_req_i(comp_req), .comp_id_i(comp_id),
        .clam_o(clam), .comp_o(comp), .irq_o(irq), .claimed_o(claimed)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    int           m_best;
    int           m_cap;
    logic         m_vld;
    logic [IW-1:0] m_cid;
    logic [N-1:0] m_clam, m_comp, m_claimed, m_nc;

    // Scan priority levels from highest down to threshold+1, lowest ID first.
    function automatic int pick(input logic [N-1:0] p_ip, input logic [N-1:0] p_ie,
                                input logic [N-1:0] p_cl, input logic [N*PW-1:0] p_pr,
                                input int th, input int masked);
        for (int p = (1 << PW) - 1; p > th; p--)
            for (int id = 1; id <= N; id++)
                if (id != masked && p_ip[id-1] && p_ie[id-1] && !p_cl[id-1]
                    && int'(p_pr[(id-1)*PW +: PW]) == p)
                    return id;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_claimed = '0; m_best = 0; m_vld = 1'b0; m_cid = '0;
            m_clam = '0; m_comp = '0;
        end else begin
            m_cap  = claim_req ? m_best : 0;
            m_nc   = m_claimed;
            m_vld  = claim_req;
            m_cid  = IW'(m_cap);
            m_clam = '0;
            m_comp = '0;
            if (m_cap != 0) begin
                m_clam[m_cap-1] = 1'b1;
                m_nc[m_cap-1]   = 1'b1;
            end
            if (comp_req && int'(comp_id) >= 1 && int'(comp_id) <= N && m_claimed[int'(comp_id)-1]) begin
                m_comp[int'(comp_id)-1] = 1'b1;
                m_nc[int'(comp_id)-1]   = 1'b0;
            end
            m_best    = pick(ip, ie, m_claimed, prio, int'(thold), m_cap);
            m_claimed = m_nc;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_prio_all(input int v);
        for (int i = 0; i < N; i++) prio[i*PW +: PW] = PW'(v);
    endtask

    task automatic set_prio(input int id, input int v);
        prio[(id-1)*PW +: PW] = PW'(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; ip = '0; ie = '0; prio = '0; thold = '0;
        claim_req = 1'b0; comp_req = 1'b0; comp_id = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Caller sits at a negedge; returns at the negedge after the sampling edge.
    task automatic pulse_claim();
        claim_req = 1'b1;
        @(negedge clk);
        claim_req = 1'b0;
    endtask

    task automatic pulse_comp(input int id);
        comp_req = 1'b1;
        comp_id  = IW'(id);
        @(negedge clk);
        comp_req = 1'b0;
        comp_id  = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; set_prio_all(1); ip = 8'hFF; ie = 8'hFF; thold = '0;
        claim_req = 1'b1; comp_req = 1'b1; comp_id = 4'd1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %0h want 0", irq); end
        n_cmp++; if (claim_vld !== 1'b0) begin n_fail++; $display("FAIL reset_claim_vld: got %0h want 0", claim_vld); end
        n_cmp++; if (claim_id !== 4'd0) begin n_fail++; $display("FAIL reset_claim_id: got %0h want 0", claim_id); end
        n_cmp++; if (clam !== 8'h00) begin n_fail++; $display("FAIL reset_clam: got %0h want 0", clam); end
        n_cmp++; if (comp !== 8'h00) begin n_fail++; $display("FAIL reset_comp: got %0h want 0", comp); end
        n_cmp++; if (claimed !== 8'h00) begin n_fail++; $display("FAIL reset_claimed: got %0h want 0", claimed); end
        rst_n = 1'b1; claim_req = 1'b0; comp_req = 1'b0; comp_id = '0;
        @(negedge clk);
        n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL reset_first_irq: got %0h want 1", irq); end
        pulse_claim();
        n_cmp++; if (claim_id !== 4'd1) begin n_fail++; $display("FAIL reset_first_id: got %0d want 1", claim_id); end
        n_cmp++; if (clam !== 8'h01) begin n_fail++; $display("FAIL reset_first_clam: got %0h want 01", clam); end
    endtask

    task automatic test_arbitration();
        int exp_ids[3] = '{3, 6, 0};
        logic [N-1:0] exp_clam;
        do_reset();
        set_prio_all(0); set_prio(3, 5); set_prio(6, 5); set_prio(2, 4);
        thold = 3'd4; ip = 8'hFF; ie = 8'hFF;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            exp_clam = '0;
            if (exp_ids[i] != 0) exp_clam[exp_ids[i]-1] = 1'b1;
            pulse_claim();
            n_cmp++; if (claim_vld !== 1'b1) begin n_fail++; $display("FAIL arb_vld[%0d]: got %0h want 1", i, claim_vld); end
            n_cmp++; if (claim_id !== IW'(exp_ids[i])) begin n_fail++; $display("FAIL arb_id[%0d]: got %0d want %0d", i, claim_id, exp_ids[i]); end
            n_cmp++; if (clam !== exp_clam) begin n_fail++; $display("FAIL arb_clam[%0d]: got %0h want %0h", i, clam, exp_clam); end
            @(negedge clk);
            n_cmp++; if (claim_vld !== 1'b0) begin n_fail++; $display("FAIL arb_vld_drop[%0d]: got %0h want 0", i, claim_vld); end
        end
        n_cmp++; if (claimed !== 8'h24) begin n_fail++; $display("FAIL arb_claimed: got %0h want 24", claimed); end
    endtask

    task automatic test_back_to_back();
        int exp_ids[4] = '{1, 2, 3, 0};
        logic [N-1:0] exp_clam[4] = '{8'h01, 8'h02, 8'h04, 8'h00};
        do_reset();
        set_prio_all(2); thold = '0; ip = 8'b0000_0111; ie = 8'hFF;
        @(negedge clk);
        claim_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 3) claim_req = 1'b0;
            n_cmp++; if (claim_id !== IW'(exp_ids[i])) begin n_fail++; $display("FAIL b2b_id[%0d]: got %0d want %0d", i, claim_id, exp_ids[i]); end
            n_cmp++; if (clam !== exp_clam[i]) begin n_fail++; $display("FAIL b2b_clam[%0d]: got %0h want %0h", i, clam, exp_clam[i]); end
        end
        n_cmp++; if (claimed !== 8'h07) begin n_fail++; $display("FAIL b2b_claimed: got %0h want 07", claimed); end
    endtask

    task automatic test_complete();
        do_reset();
        set_prio_all(1); thold = '0; ip = 8'h10; ie = 8'hFF;
        @(negedge clk);
        pulse_claim();
        n_cmp++; if (claim_id !== 4'd5) begin n_fail++; $display("FAIL comp_claim_id: got %0d want 5", claim_id); end
        pulse_comp(5);
        n_cmp++; if (comp !== 8'h10) begin n_fail++; $display("FAIL comp_pulse: got %0h want 10", comp); end
        n_cmp++; if (claimed !== 8'h00) begin n_fail++; $display("FAIL comp_cleared: got %0h want 00", claimed); end
        pulse_comp(5);
        n_cmp++; if (comp !== 8'h00) begin n_fail++; $display("FAIL comp_repeat: got %0h want 00", comp); end
        pulse_claim();
        n_cmp++; if (claimed !== 8'h10) begin n_fail++; $display("FAIL comp_reclaim: got %0h want 10", claimed); end
        pulse_comp(0);
        n_cmp++; if (comp !== 8'h00) begin n_fail++; $display("FAIL comp_id0: got %0h want 00", comp); end
        pulse_comp(9);
        n_cmp++; if (comp !== 8'h00) begin n_fail++; $display("FAIL comp_id9: got %0h want 00", comp); end
        n_cmp++; if (claimed !== 8'h10) begin n_fail++; $display("FAIL comp_kept: got %0h want 10", claimed); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        set_prio_all(1); thold = '0; ip = 8'b0000_1010; ie = 8'hFF;
        @(negedge clk);
        pulse_claim();
        n_cmp++; if (claim_id !== 4'd2) begin n_fail++; $display("FAIL sim_first_id: got %0d want 2", claim_id); end
        claim_req = 1'b1;
        pulse_comp(2);
        claim_req = 1'b0;
        n_cmp++; if (clam !== 8'h08) begin n_fail++; $display("FAIL sim_clam: got %0h want 08", clam); end
        n_cmp++; if (comp !== 8'h02) begin n_fail++; $display("FAIL sim_comp: got %0h want 02", comp); end
        n_cmp++; if (claimed !== 8'h08) begin n_fail++; $display("FAIL sim_claimed: got %0h want 08", claimed); end
    endtask

    task automatic test_thresh_enable();
        do_reset();
        set_prio_all(0); set_prio(1, 3); set_prio(2, 7);
        thold = 3'd2; ip = 8'h03; ie = 8'hFF;
        @(negedge clk);
        pulse_claim();
        n_cmp++; if (claim_id !== 4'd2) begin n_fail++; $display("FAIL th_claim_id: got %0d want 2", claim_id); end
        n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL th_irq_src1: got %0h want 1", irq); end
        thold = 3'd3;
        @(negedge clk);
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL th_raise: got %0h want 0", irq); end
        n_cmp++; if (claimed !== 8'h02) begin n_fail++; $display("FAIL th_claim_kept: got %0h want 02", claimed); end
        thold = 3'd0;
        @(negedge clk);
        n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL th_lower: got %0h want 1", irq); end
        ie = 8'hFE;
        @(negedge clk);
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL th_disable: got %0h want 0", irq); end
        n_cmp++; if (claimed !== 8'h02) begin n_fail++; $display("FAIL en_claim_kept: got %0h want 02", claimed); end
    endtask

    task automatic test_random();
        int start;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            n_cmp++; if (irq !== (m_best != 0)) begin n_fail++; $display("FAIL rnd_irq@%0d: got %0h want %0h", cyc, irq, (m_best != 0)); end
            n_cmp++; if (claim_vld !== m_vld) begin n_fail++; $display("FAIL rnd_vld@%0d: got %0h want %0h", cyc, claim_vld, m_vld); end
            n_cmp++; if (claim_id !== m_cid) begin n_fail++; $display("FAIL rnd_id@%0d: got %0d want %0d", cyc, claim_id, m_cid); end
            n_cmp++; if (clam !== m_clam) begin n_fail++; $display("FAIL rnd_clam@%0d: got %0h want %0h", cyc, clam, m_clam); end
            n_cmp++; if (comp !== m_comp) begin n_fail++; $display("FAIL rnd_comp@%0d: got %0h want %0h", cyc, comp, m_comp); end
            n_cmp++; if (claimed !== m_claimed) begin n_fail++; $display("FAIL rnd_claimed@%0d: got %0h want %0h", cyc, claimed, m_claimed); end
            rst_n = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 3) == 0) ip    = N'($urandom);
            if ($urandom_range(0, 7) == 0) ie    = N'($urandom) | N'($urandom);
            if ($urandom_range(0, 7) == 0) prio  = (N*PW)'($urandom);
            if ($urandom_range(0, 9) == 0) thold = PW'($urandom_range(0, 4));
            claim_req = ($urandom_range(0, 2) == 0);
            comp_req  = ($urandom_range(0, 2) == 0);
            comp_id   = IW'($urandom_range(0, 15));
            if (m_claimed != '0 && $urandom_range(0, 3) != 0) begin
                start = $urandom_range(0, N - 1);
                for (int j = 0; j < N; j++)
                    if (m_claimed[(start + j) % N]) comp_id = IW'((start + j) % N + 1);
            end
        end
        claim_req = 1'b0;
        comp_req  = 1'b0;
        rst_n     = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; ip = '0; ie = '0; prio = '0; thold = '0;
        claim_req = 1'b0; comp_req = 1'b0; comp_id = '0;
        test_reset();
        test_arbitration();
        test_back_to_back();
        test_complete();
        test_simultaneous();
        test_thresh_enable();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
